// File: rtl/sync_fifo_ctrl_if.sv
// Push/pop handshake and status bundle for sync_fifo_ctrl.
// The master side is the producer/consumer; the slave side is the FIFO.
interface sync_fifo_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);
  logic              wr_en_i;
  logic [DATA_W-1:0] data_i;
  logic              rd_en_i;
  logic              clr_err_i;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              full_o;
  logic              empty_o;
  logic              almost_full_o;
  logic              almost_empty_o;
  logic [CNT_W-1:0]  count_o;
  logic              overflow_o;
  logic              underflow_o;

  modport master (
    output wr_en_i, data_i, rd_en_i, clr_err_i,
    input  data_o, valid_o, full_o, empty_o, almost_full_o, almost_empty_o,
           count_o, overflow_o, underflow_o
  );

  modport slave (
    input  wr_en_i, data_i, rd_en_i, clr_err_i,
    output data_o, valid_o, full_o, empty_o, almost_full_o, almost_empty_o,
           count_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: wrap-bit pointers, occupancy count, status
// flags, sticky error flags and a registered read port over an unreset array.
module sync_fifo_ctrl #(
  parameter int DEPTH     = 8,
  parameter int DATA_W    = 8,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  sync_fifo_ctrl_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW:0]       wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]     count_reg, count_next;
  logic [DATA_W-1:0] data_reg;
  logic              valid_reg;
  logic              overflow_reg, overflow_next;
  logic              underflow_reg, underflow_next;
  logic              full, empty;
  logic              wr_acc, rd_acc;

  // Equal index with differing wrap bit means the writer has lapped the reader.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                 (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

  assign rd_acc = bus.rd_en_i && !empty;
  assign wr_acc = bus.wr_en_i && (!full || rd_acc);

  always_comb begin
    count_next = count_reg;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // A rejection in the same cycle as a clear keeps the flag set.
  always_comb begin
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (bus.clr_err_i) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (bus.wr_en_i && !wr_acc) overflow_next  = 1'b1;
    if (bus.rd_en_i && !rd_acc) underflow_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_reg[AW-1:0]] <= bus.data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (rd_acc) begin
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        data_reg   <= mem[rd_ptr_reg[AW-1:0]];
      end
      count_reg     <= count_next;
      valid_reg     <= rd_acc;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign bus.data_o         = data_reg;
  assign bus.valid_o        = valid_reg;
  assign bus.full_o         = full;
  assign bus.empty_o        = empty;
  assign bus.almost_full_o  = (count_reg >= CW'(AFULL_TH));
  assign bus.almost_empty_o = (count_reg <= CW'(AEMPTY_TH));
  assign bus.count_o        = count_reg;
  assign bus.overflow_o     = overflow_reg;
  assign bus.underflow_o    = underflow_reg;
endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Single-clock synchronous FIFO: pointer management, occupancy tracking, status flags and registered read data around an internal DEPTH x DATA_W storage array. It gives a single-clock producer and consumer one push/pop interface with full/empty protection and sticky error reporting. It is the single-clock counterpart of the team's dual-port FIFO storage block.

## Interface
- DEPTH, 8: number of entries; power of 2, >= 2
- DATA_W, 8: data width in bits
- AFULL_TH, 6: almost_full_o asserts when count >= AFULL_TH; 1..DEPTH
- AEMPTY_TH, 2: almost_empty_o asserts when count <= AEMPTY_TH; 0..DEPTH-1
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en_i  in  1  push request
- data_i  in  DATA_W  push data
- rd_en_i  in  1  pop request
- clr_err_i  in  1  clears the sticky error flags
- data_o  out  DATA_W  registered pop data
- valid_o  out  1  one-cycle pulse; data_o holds newly popped word
- full_o  out  1  count == DEPTH
- empty_o  out  1  count == 0
- almost_full_o  out  1  count >= AFULL_TH
- almost_empty_o  out  1  count <= AEMPTY_TH
- count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow_o  out  1  sticky: a push was rejected
- underflow_o  out  1  sticky: a pop was rejected

## Operation
- Pointers wr_ptr/rd_ptr are AW+1 bits wide, with AW = $clog2(DEPTH). Low AW bits address the storage array. The MSB is the wrap bit. Increment is modulo 2^(AW+1).
- Push accepted (wr_acc) when wr_en_i && (!full_o || rd_acc). An accepted push writes mem[wr_ptr[AW-1:0]] <= data_i and increments wr_ptr.
- Pop accepted (rd_acc) when rd_en_i && !empty_o. An accepted pop sets data_o <= mem[rd_ptr[AW-1:0]] and increments rd_ptr.
- Full with both requests: both are accepted and count is unchanged. The read returns the old (oldest) word at the shared address, not data_i.
- Empty with both requests: the push is accepted and the pop is rejected. There is no bypass from data_i to data_o.
- count_o: +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds DEPTH and never goes below 0.
- Flags are derived from registered count or pointers. They reflect state after the most recent edge and carry no combinational path from the *_en_i inputs.
- overflow_o sets when wr_en_i && !wr_acc. underflow_o sets when rd_en_i && !rd_acc.
- clr_err_i clears both error flags. A set condition in the same cycle wins, and the flag stays 1.
- Rejected requests change no pointer, count or storage state.
- Storage array is not reset. Contents are undefined until written.

## Timing
- Reset (rst_n low, asynchronous, effective immediately without a clock edge):
  - pointers 0, count_o 0, data_o 0, valid_o 0
  - empty_o 1, almost_empty_o 1, full_o 0, almost_full_o 0
  - overflow_o 0, underflow_o 0
- Release of rst_n takes effect synchronously; the first accepted operation is on the first rising edge after release.
- Push latency: a word pushed at edge N is poppable from edge N+1. empty_o deasserts after edge N.
- Pop latency: rd_en_i sampled at edge N gives data_o and valid_o=1 after edge N. valid_o drops after edge N+1 unless another pop is accepted.
- data_o holds its last value when no pop is accepted.
- Back-to-back pops every cycle give one word per cycle, in push order.
- Wrap-around: after the index passes DEPTH-1 it returns to 0 and the wrap bit toggles. Full/empty are disambiguated by the wrap bit (equal index, differing MSB = full).

## Test plan
- Reset: drive rst_n=0 asynchronously mid-cycle with count_o=5 -> all outputs immediately at reset values (empty_o=1, count_o=0, data_o=0x00); release, push 0x3C, pop -> data_o=0x3C, valid_o=1.
- Fill: 8 pushes 0x10..0x17 -> almost_full_o=1 after the 6th push, full_o=1 and count_o=8 after the 8th; a 9th push of 0xFF -> rejected, overflow_o=1, count_o stays 8.
- Drain: 8 pops -> data_o 0x10..0x17 in order, each with valid_o=1 one edge after rd_en_i; empty_o=1 after the last; a 9th pop -> underflow_o=1, valid_o=0, data_o holds 0x17.
- Wrap: push 5/pop 5, then push 0x20..0x27 and pop 8 -> 0x20..0x27 in order, full_o=1 at count_o 8 with wrapped pointers, no error flags set.
- Simultaneous at full (contents 0x10..0x17): rd_en_i=wr_en_i=1, data_i=0xAA -> data_o=0x10, count_o=8, overflow_o=0; after 7 more pops, the 8th returns 0xAA.
- Simultaneous at empty: rd_en_i=wr_en_i=1, data_i=0x55 -> count_o=1, underflow_o=1, valid_o=0. Then clr_err_i=1 with rd_en_i=1 -> 0x55 popped and underflow_o=0. Then clr_err_i=1 with rd_en_i=1 while empty -> underflow_o remains 1 (set wins).
